// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider controller: accepts one operand pair, runs one
// shift-subtract step per clock, then holds the result until it is taken.
// A zero divisor completes on a short path with the div_by_zero flag set.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] wq_q;
  // The remainder never reaches the divisor, so its top bit is kept only in
  // the trial value t.
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem_d;
  logic [WIDTH-1:0] step_wq_d;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial      = {rem_q, wq_q[WIDTH-1]};
    step_rem_d = trial[WIDTH-1:0];
    step_wq_d  = {wq_q[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, divisor_q}) begin
      // Difference is below the divisor, so the low WIDTH bits are exact.
      step_rem_d = trial[WIDTH-1:0] - divisor_q;
      step_wq_d  = {wq_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM plus working and result registers; flush beats every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      divisor_q   <= '0;
      wq_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (in_b != '0) begin
              divisor_q <= in_b;
              wq_q      <= in_a;
              rem_q     <= '0;
              cnt_q     <= '0;
              state_q   <= StCalc;
            end else begin
              quotient_q  <= '1;
              remainder_q <= in_a;
              dbz_q       <= 1'b1;
              state_q     <= StHold;
            end
          end
        end
        StCalc: begin
          rem_q <= step_rem_d;
          wq_q  <= step_wq_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            quotient_q  <= step_wq_d;
            remainder_q <= step_rem_d;
            dbz_q       <= 1'b0;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and status decodes depend on registered state only.
  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StHold);
    busy        = (state_q != StIdle);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl at WIDTH = 4.
module tb_div_seq_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t last_res;
  int   n_checks;
  int   n_fail;

  div_seq_ctrl #(.WIDTH(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction; hold > 0 keeps out_ready low for that many HOLD cycles.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int   lat;
    exp_t e;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    sb.push_back(model(a, b));
    lat = 0;
    while (!out_valid && lat < int'(W) + 8) begin
      tick();
      lat++;
    end
    check_eq("latency", lat, (b == '0) ? 0 : W);
    e = sb.pop_front();
    last_res = e;
    check_eq("quotient", quotient, e.q);
    check_eq("remainder", remainder, e.r);
    check_eq("div_by_zero", div_by_zero, e.dbz);
    check_eq("hold_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a     = a ^ 4'h5;
      in_b     = b | 4'h1;
      tick();
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_quotient", quotient, e.q);
      check_eq("bp_remainder", remainder, e.r);
      check_eq("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("idle_out_valid", out_valid, 0);
    check_eq("idle_in_ready", in_ready, 1);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    int seen_valid;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    last_res  = '0;
    #3;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Directed cases.
    run(4'd9, 4'd2, 0);
    run(4'd9, 4'd0, 0);
    run(4'd15, 4'd15, 0);
    run(4'd3, 4'd7, 0);
    run(4'd15, 4'd1, 0);
    run(4'd0, 4'd5, 0);
    run(4'd13, 4'd4, 6);

    // Flush at E2 of 12 / 5.
    in_a     = 4'd12;
    in_b     = 4'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("calc_busy", busy, 1);
    check_eq("calc_in_ready", in_ready, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_in_ready", in_ready, 1);
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_quotient", quotient, last_res.q);
    check_eq("flush_remainder", remainder, last_res.r);
    check_eq("flush_dbz", div_by_zero, last_res.dbz);
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    check_eq("flush_no_output", seen_valid, 0);
    // Flush in IDLE with in_valid: nothing accepted.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_a     = 4'd7;
    in_b     = 4'd2;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("idle_flush_in_ready", in_ready, 1);
    check_eq("idle_flush_busy", busy, 0);
    run(4'd12, 4'd5, 0);

    // Asynchronous reset during CALC, checked before any clock edge.
    in_a     = 4'd13;
    in_b     = 4'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_in_ready", in_ready, 1);
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_quotient", quotient, 0);
    check_eq("arst_remainder", remainder, 0);
    check_eq("arst_dbz", div_by_zero, 0);
    tick();
    rst_n = 1'b1;
    check_eq("post_rst_in_ready", in_ready, 1);
    run(4'd13, 4'd3, 0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run(W'(a), W'(b), 0);
      end
    end

    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
